// File: rtl/updown_pkg.sv
// updown_pkg: shared width default, FSM state and step-class types for the up/down counter and its monitor.
package updown_pkg;
    localparam int CNT_W = 3;
    typedef enum logic {PRIME, TRACK} state_e;
    typedef enum logic [1:0] {STEP_HOLD, STEP_UP, STEP_DOWN, STEP_ERR} step_e;
endpackage

// File: rtl/updown_step_classify.sv
// updown_step_classify: classifies one counter step from the previous sample and flags wrap-around.
module updown_step_classify
    import updown_pkg::*;
#(
    parameter int CNT_W = updown_pkg::CNT_W
) (
    input  logic [CNT_W-1:0] prev_cnt_i,
    input  logic [CNT_W-1:0] cnt_i,
    input  logic             prev_up_i,
    output step_e            step_o,
    output logic             wrap_o
);
    logic [CNT_W-1:0] delta;
    assign delta = cnt_i - prev_cnt_i;
    always_comb begin
        step_o = (delta == '0)                     ? STEP_HOLD :
                 (delta == CNT_W'(1) && prev_up_i)  ? STEP_UP   :
                 (delta == '1 && !prev_up_i)        ? STEP_DOWN : STEP_ERR;
        wrap_o = (step_o == STEP_UP && cnt_i == '0) || (step_o == STEP_DOWN && cnt_i == '1);
    end
endmodule

// File: rtl/updown_wrap_monitor.sv
// updown_wrap_monitor: watches the up/down counter, pulses on wraps and illegal steps,
// keeps a signed lap count and a saturating error count.
module updown_wrap_monitor
    import updown_pkg::*;
#(
    parameter int CNT_W = updown_pkg::CNT_W,
    parameter int LAP_W = 8,
    parameter int ERR_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [CNT_W-1:0] count_in,
    input  logic             up_in,
    input  logic             lap_clr,
    output logic             wrap_up,
    output logic             wrap_down,
    output logic             step_err,
    output logic [LAP_W-1:0] lap_count,
    output logic [ERR_W-1:0] err_count,
    output logic             primed
);
    state_e           state_q, state_d;
    logic [CNT_W-1:0] prev_cnt_q;
    logic             prev_up_q;
    logic             wrap_up_q, wrap_down_q, step_err_q;
    logic             wrap_up_d, wrap_down_d, step_err_d;
    logic [LAP_W-1:0] lap_q, lap_d;
    logic [ERR_W-1:0] err_q, err_d;
    step_e            step_cls;
    logic             wrap;

    updown_step_classify #(.CNT_W(CNT_W)) u_cls (
        .prev_cnt_i(prev_cnt_q),
        .cnt_i     (count_in),
        .prev_up_i (prev_up_q),
        .step_o    (step_cls),
        .wrap_o    (wrap)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= PRIME;
        else       state_q <= state_d;
    end

    // PRIME only lasts for the first edge after reset; nothing but reset leaves TRACK
    always_comb begin
        state_d = (state_q == PRIME) ? TRACK : state_q;
    end

    always_comb begin
        wrap_up_d   = state_q == TRACK && step_cls == STEP_UP && wrap;
        wrap_down_d = state_q == TRACK && step_cls == STEP_DOWN && wrap;
        step_err_d  = state_q == TRACK && step_cls == STEP_ERR;
        lap_d       = lap_clr ? '0 : lap_q + LAP_W'(wrap_up_d) - LAP_W'(wrap_down_d);
        err_d       = (step_err_d && err_q != '1) ? err_q + ERR_W'(1) : err_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_cnt_q  <= '0;
            prev_up_q   <= 1'b0;
            wrap_up_q   <= 1'b0;
            wrap_down_q <= 1'b0;
            step_err_q  <= 1'b0;
            lap_q       <= '0;
            err_q       <= '0;
        end else begin
            prev_cnt_q  <= count_in;
            prev_up_q   <= up_in;
            wrap_up_q   <= wrap_up_d;
            wrap_down_q <= wrap_down_d;
            step_err_q  <= step_err_d;
            lap_q       <= lap_d;
            err_q       <= err_d;
        end
    end

    assign wrap_up   = wrap_up_q;
    assign wrap_down = wrap_down_q;
    assign step_err  = step_err_q;
    assign lap_count = lap_q;
    assign err_count = err_q;
    assign primed    = state_q == TRACK;
endmodule

// File: tb/tb_updown_wrap_monitor.sv
// tb_updown_wrap_monitor: scoreboard bench; stimulus pushes reference-model expectations, a monitor pops and compares.
module tb_updown_wrap_monitor;
    typedef struct packed {
        logic       wu;
        logic       wd;
        logic       se;
        logic [7:0] lap;
        logic [3:0] err;
        logic       pr;
    } obs_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [2:0] count_in = '0;
    logic       up_in = 1'b1;
    logic       lap_clr = 1'b0;
    logic       wrap_up, wrap_down, step_err, primed;
    logic [7:0] lap_count;
    logic [3:0] err_count;

    obs_t q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    bit   m_pr = 0;
    bit   m_pup = 0;
    int   m_prev = 0;
    int   m_lap = 0;
    int   m_err = 0;

    updown_wrap_monitor dut (
        .clk      (clk),
        .reset    (reset),
        .count_in (count_in),
        .up_in    (up_in),
        .lap_clr  (lap_clr),
        .wrap_up  (wrap_up),
        .wrap_down(wrap_down),
        .step_err (step_err),
        .lap_count(lap_count),
        .err_count(err_count),
        .primed   (primed)
    );

    always #5 clk = ~clk;

    function automatic obs_t observed();
        return '{wu: wrap_up, wd: wrap_down, se: step_err, lap: lap_count, err: err_count, pr: primed};
    endfunction

    function automatic void chk(input string name, input obs_t act, input obs_t exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got wu=%b wd=%b se=%b lap=%h err=%0d pr=%b, need wu=%b wd=%b se=%b lap=%h err=%0d pr=%b",
                     name, $time, act.wu, act.wd, act.se, act.lap, act.err, act.pr,
                     exp.wu, exp.wd, exp.se, exp.lap, exp.err, exp.pr);
        end
    endfunction

    // Reference model: signed step size in -3..4, legality from the sampled direction, wrap when the value crosses the top/bottom.
    task automatic step(input int c, input bit u, input bit clr, input bit r);
        obs_t e;
        int   s;
        bit   up_ok, dn_ok;
        @(negedge clk);
        count_in = 3'(c);
        up_in    = u;
        lap_clr  = clr;
        reset    = r;
        e        = '0;
        if (r) begin
            m_pr = 0; m_lap = 0; m_err = 0;
        end else begin
            if (m_pr) begin
                s = ((c - m_prev) % 8 + 8) % 8;
                if (s > 4) s = s - 8;
                up_ok = (s == 1) && m_pup;
                dn_ok = (s == -1) && !m_pup;
                e.wu  = up_ok && c < m_prev;
                e.wd  = dn_ok && c > m_prev;
                e.se  = s != 0 && !up_ok && !dn_ok;
                m_lap = m_lap + int'(e.wu) - int'(e.wd);
                if (e.se && m_err < 15) m_err++;
            end
            if (clr) m_lap = 0;
            m_pr   = 1;
            m_prev = c;
            m_pup  = u;
        end
        e.lap = m_lap[7:0];
        e.err = 4'(m_err);
        e.pr  = m_pr;
        q.push_back(e);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) chk("scoreboard", observed(), q.pop_front());
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, need completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int cur;
        bit u;
        #1;
        chk("reset_state", observed(), '0);
        repeat (2) step(0, 1, 0, 1);
        for (int i = 0; i <= 8; i++) step(i % 8, 1, 0, 0);
        step(0, 0, 0, 0);
        for (int i = 7; i >= 0; i--) step(i, 0, 0, 0);
        step(7, 0, 0, 0);
        for (int i = 0; i < 20; i++) begin
            step(2, 1, 0, 0);
            step(5, 1, 0, 0);
        end
        step(3, 0, 0, 0);
        step(4, 0, 0, 0);
        step(7, 1, 0, 0);
        step(0, 1, 1, 0);
        for (int i = 1; i <= 24; i++) step(i % 8, 1, 0, 0);
        for (int i = 1; i <= 5; i++) step(i, 1, 0, 0);
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        chk("async_reset", observed(), '0);
        m_pr = 0; m_lap = 0; m_err = 0;
        step(5, 1, 0, 1);
        step(6, 1, 0, 0);
        step(7, 1, 0, 0);
        step(0, 1, 0, 0);
        cur = 0;
        u   = 1;
        for (int i = 0; i < 400; i++) begin
            int r;
            r = int'($urandom_range(0, 19));
            if (r < 13)      cur = (cur + (u ? 1 : 7)) % 8;
            else if (r < 17) cur = cur;
            else             cur = int'($urandom_range(0, 7));
            if ($urandom_range(0, 7) == 0) u = ~u;
            step(cur, u, $urandom_range(0, 15) == 0, $urandom_range(0, 99) == 0);
        end
        step(cur, u, 0, 0);
        repeat (2) @(posedge clk);
        #2;
        n_cmp++;
        if (q.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d pending expectations, need 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end
endmodule
